// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC and runs the req/ready fetch handshake.
// It holds each fetched instruction until the core acks it, then selects the next PC.
module pc_sequencer #(
   parameter logic [31:0] RESET_VEC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ready,
   input  logic [31:0] i_imem_rdata,
   output logic        o_instr_valid,
   output logic [31:0] o_instr,
   output logic [31:0] o_instr_pc,
   input  logic        i_instr_ack,
   input  logic        i_br_taken,
   input  logic [31:0] i_br_target,
   input  logic        i_jmp,
   input  logic [31:0] i_jmp_target,
   input  logic        i_exc,
   input  logic        i_eret,
   output logic [31:0] o_pc,
   output logic [31:0] o_epc
);

   typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_epc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic [31:0] w_next_pc;
   logic        w_fetch_done;
   logic        w_retire;

   function automatic logic [31:0] align4(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_BOOT;
      else          r_state <= w_state_nxt;
   end

   assign w_fetch_done = (r_state == S_FETCH) && i_imem_ready;
   assign w_retire     = (r_state == S_HOLD) && i_instr_ack;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_FETCH;
         S_FETCH: if (i_imem_ready) w_state_nxt = S_HOLD;
         S_HOLD:  if (i_instr_ack)  w_state_nxt = S_FETCH;
         default: w_state_nxt = S_BOOT;
      endcase
   end

   // Redirect priority: exception, eret, jump, taken branch, sequential.
   always_comb begin
      w_next_pc = r_instr_pc + 32'd4;
      if (i_exc)           w_next_pc = EXC_VEC;
      else if (i_eret)     w_next_pc = r_epc;
      else if (i_jmp)      w_next_pc = align4(i_jmp_target);
      else if (i_br_taken) w_next_pc = align4(i_br_target);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pc       <= RESET_VEC;
         r_epc      <= 32'd0;
         r_instr    <= 32'd0;
         r_instr_pc <= 32'd0;
      end else begin
         if (w_fetch_done) begin
            r_instr    <= i_imem_rdata;
            r_instr_pc <= r_pc;
         end
         if (w_retire) begin
            r_pc <= w_next_pc;
            if (i_exc) r_epc <= r_instr_pc;
         end
      end
   end

   // Decoded straight from state so an async reset drops them without a clock.
   assign o_imem_req    = (r_state == S_FETCH);
   assign o_instr_valid = (r_state == S_HOLD);
   assign o_imem_addr   = r_pc;
   assign o_pc          = r_pc;
   assign o_epc         = r_epc;
   assign o_instr       = r_instr;
   assign o_instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stalls, redirects, exception/return,
// PC wrap and asynchronous reset in HOLD, against hand-computed addresses.
module tb_pc_sequencer;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ack;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        exc;
   logic        eret;
   logic [31:0] pc;
   logic [31:0] epc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   // Memory model: word is address XOR KEY; garbage when not ready.
   assign imem_rdata = imem_ready ? (imem_addr ^ KEY) : 32'hBAD0_BAD0;

   pc_sequencer dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_imem_req   (imem_req),
      .o_imem_addr  (imem_addr),
      .i_imem_ready (imem_ready),
      .i_imem_rdata (imem_rdata),
      .o_instr_valid(instr_valid),
      .o_instr      (instr),
      .o_instr_pc   (instr_pc),
      .i_instr_ack  (instr_ack),
      .i_br_taken   (br_taken),
      .i_br_target  (br_target),
      .i_jmp        (jmp),
      .i_jmp_target (jmp_target),
      .i_exc        (exc),
      .i_eret       (eret),
      .o_pc         (pc),
      .o_epc        (epc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_redirects();
      br_taken = 1'b0; br_target = 32'd0;
      jmp = 1'b0;      jmp_target = 32'd0;
      exc = 1'b0;      eret = 1'b0;
   endtask

   // Entered in FETCH; waits `w` cycles with ready low, then completes the fetch.
   task automatic do_fetch(input logic [31:0] a, input int w);
      for (int i = 0; i < w; i++) begin
         chk("stall_req", {31'd0, imem_req}, 32'd1);
         chk("stall_addr", imem_addr, a);
         imem_ready = 1'b0;
         step();
      end
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      chk("fetch_addr", imem_addr, a);
      chk("fetch_pc", pc, a);
      chk("fetch_novalid", {31'd0, instr_valid}, 32'd0);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      chk("hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_instr", instr, a ^ KEY);
      chk("hold_ipc", instr_pc, a);
   endtask

   // Entered in HOLD with redirect inputs already set; acks after `w` idle cycles.
   task automatic do_ack(input logic [31:0] a, input int w);
      for (int i = 0; i < w; i++) begin
         instr_ack = 1'b0;
         step();
         chk("hold_wait_valid", {31'd0, instr_valid}, 32'd1);
         chk("hold_wait_instr", instr, a ^ KEY);
         chk("hold_wait_ipc", instr_pc, a);
      end
      instr_ack = 1'b1;
      step();
      instr_ack = 1'b0;
      clear_redirects();
      chk("ack_valid", {31'd0, instr_valid}, 32'd0);
      chk("ack_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; imem_ready = 1'b0; instr_ack = 1'b0;
      clear_redirects();
      step();
      step();
      chk("rst_pc", pc, 32'h0000_3000);
      chk("rst_epc", epc, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_ipc", instr_pc, 32'd0);

      rst_n = 1'b1;
      #2;
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      step();

      // Stalled first fetch, stalled hold, then sequential flow.
      do_fetch(32'h0000_3000, 3);
      do_ack(32'h0000_3000, 2);
      do_fetch(32'h0000_3004, 0);
      do_ack(32'h0000_3004, 0);
      do_fetch(32'h0000_3008, 0);

      exc = 1'b1; eret = 1'b1;
      do_ack(32'h0000_3008, 0);
      chk("exc_epc", epc, 32'h0000_3008);

      // Spurious ack and redirect request while fetching must be ignored.
      instr_ack = 1'b1; jmp = 1'b1; jmp_target = 32'h0000_7000;
      step();
      instr_ack = 1'b0;
      clear_redirects();
      chk("spur_pc", pc, 32'h0000_4180);
      do_fetch(32'h0000_4180, 0);
      eret = 1'b1;
      do_ack(32'h0000_4180, 0);
      chk("eret_epc", epc, 32'h0000_3008);

      do_fetch(32'h0000_3008, 0);
      do_ack(32'h0000_3008, 0);
      do_fetch(32'h0000_300C, 0);
      do_ack(32'h0000_300C, 0);
      do_fetch(32'h0000_3010, 0);
      br_taken = 1'b1; br_target = 32'h0000_3100;
      do_ack(32'h0000_3010, 0);
      do_fetch(32'h0000_3100, 0);
      jmp = 1'b1; jmp_target = 32'h0000_3203;
      br_taken = 1'b1; br_target = 32'h0000_3300;
      do_ack(32'h0000_3100, 0);
      do_fetch(32'h0000_3200, 0);
      jmp = 1'b1; jmp_target = 32'hFFFF_FFFF;
      do_ack(32'h0000_3200, 0);
      do_fetch(32'hFFFF_FFFC, 0);
      do_ack(32'hFFFF_FFFC, 0);
      chk("epc_kept", epc, 32'h0000_3008);
      do_fetch(32'h0000_0000, 0);

      // Asynchronous reset in the middle of a HOLD cycle.
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_pc", pc, 32'h0000_3000);
      chk("arst_epc", epc, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Instruction-fetch sequencer that owns the program counter of the CPU. It issues fetch requests to instruction memory with a req/ready handshake and holds each fetched instruction for the decode/execute stage until it is acknowledged. It then selects the next PC by priority: exception, eret, jump, taken branch, PC+4. It also keeps the EPC register for exception return.

## Interface
- RESET_VEC, 32'h0000_3000, PC value loaded on reset
- EXC_VEC, 32'h0000_4180, exception handler entry address
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; equals pc
- imem_ready  in  1  memory accepts request and returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a valid instruction for the core
- instr  out  32  held instruction word
- instr_pc  out  32  address of held instruction
- instr_ack  in  1  core retires held instruction; redirect inputs are sampled this cycle
- br_taken  in  1  conditional branch taken
- br_target  in  32  branch target
- jmp  in  1  jump/jr/jal
- jmp_target  in  32  jump target
- exc  in  1  held instruction raised an exception
- eret  in  1  return from exception
- pc  out  32  current PC register
- epc  out  32  saved exception PC

## Operation
- States: BOOT, FETCH, HOLD.
- BOOT: imem_req=0. Advances to FETCH unconditionally after one cycle.
- FETCH: imem_req=1 and imem_addr=pc, held stable until imem_ready.
  - On imem_ready: instr<=imem_rdata, instr_pc<=pc, go to HOLD.
- HOLD: instr_valid=1 and imem_req=0. instr/instr_pc are stable until instr_ack.
  - On instr_ack: pc<=next_pc, go to FETCH.
- next_pc priority, first match wins:
  - exc: EXC_VEC, and epc<=instr_pc.
  - eret: epc.
  - jmp: jmp_target.
  - br_taken: br_target.
  - otherwise: instr_pc+4.
- Arithmetic and alignment:
  - Targets have bits[1:0] forced to 0.
  - PC+4 is modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000.
- Ignored inputs:
  - instr_ack, exc, eret, jmp and br_taken outside HOLD.
  - imem_ready outside FETCH.
  - imem_rdata when imem_ready=0.
- Simultaneous exc and eret: exc wins and epc is overwritten with instr_pc.
- epc changes only on reset or on an accepted exc.

## Timing
- Reset values: pc=RESET_VEC, epc=0, instr=0, instr_pc=0, imem_req=0, instr_valid=0, state=BOOT.
- Reset is asynchronous. Asserting rst_n mid-fetch or mid-hold drops imem_req and instr_valid immediately, with no waiting for clk.
- Sequence after rst_n deasserts:
  - Cycle 0: BOOT.
  - Cycle 1: FETCH with imem_req=1, imem_addr=RESET_VEC.
- Fetch latency: if imem_ready is high in FETCH cycle N, then instr_valid=1 in cycle N+1.
- Minimum throughput: 2 cycles per instruction (ready in the first FETCH cycle, ack in the first HOLD cycle).
- Redirect latency: instr_ack in cycle N gives imem_addr=next_pc with imem_req=1 in cycle N+1. No wrong-path fetch is ever issued.
- Wait states:
  - imem_ready low for K cycles extends FETCH by K cycles.
  - instr_ack low extends HOLD indefinitely.
- pc updates only on the clock edge after instr_ack in HOLD.

## Test plan
- Reset and boot: pulse rst_n low for 2 cycles then release -> BOOT for 1 cycle, then imem_req=1 with imem_addr=32'h0000_3000. pc and instr_valid stay at reset values during reset.
- Sequential flow: imem_ready always 1, instr_ack in every HOLD, no redirects -> fetch addresses 0x3000, 0x3004, 0x3008. instr_valid toggles every cycle (2 cycles per instruction).
- Stalls: hold imem_ready=0 for 3 cycles, then instr_ack=0 for 2 cycles -> imem_addr stays 0x3000 for 4 FETCH cycles. instr and instr_pc stay stable for 3 HOLD cycles.
- Redirect priority:
  - At instr_pc=0x3010, br_taken=1 with br_target=0x3100 -> next fetch 0x3100.
  - Next instruction: jmp=1 with jmp_target=0x3203 and br_taken=1 -> next fetch 0x3200.
- Exception and return:
  - At instr_pc=0x3008, assert exc together with eret=1 -> epc=0x3008 and next fetch 0x4180.
  - A later eret -> next fetch 0x3008.
- Boundaries:
  - pc=0xFFFF_FFFC with plain ack -> next fetch 0x0000_0000.
  - Assert rst_n low mid-HOLD at a non-edge time -> instr_valid=0 immediately and pc=0x3000.
  - Spurious instr_ack during FETCH -> ignored.
